// File: rtl/token_stream_receiver.sv
// Receives the validator's token byte stream, reassembles tokens LSB-byte-first
// and presents them on a valid/ready register with short/sequence/overrun reporting.
module token_stream_receiver #(
    parameter int NBYTES  = 8,
    parameter int COUNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 byte_in,
    input  logic                       stream_active,
    input  logic [$clog2(NBYTES)-1:0]  byte_idx,
    input  logic                       token_ready,
    input  logic                       clr_err,
    output logic [8*NBYTES-1:0]        token_out,
    output logic                       token_valid,
    output logic                       err_short,
    output logic                       err_seq,
    output logic                       err_overrun,
    output logic [2:0]                 err_sticky,
    output logic [COUNT_W-1:0]         tok_count
);

    localparam int IDX_W = $clog2(NBYTES);
    localparam int TOK_W = 8 * NBYTES;
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   exp_q, exp_d;
    logic [TOK_W-1:0]   buf_q, buf_d;
    logic [TOK_W-1:0]   token_q, token_d;
    logic               valid_q, valid_d;
    logic               short_q, seq_q, ovr_q;
    logic [2:0]         sticky_q, sticky_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               done_s, short_s, seq_s, ovr_s, load_s, hs_s;

    // Collection FSM: byte placement, index sequencing and error detection
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        buf_d   = buf_q;
        done_s  = 1'b0;
        short_s = 1'b0;
        seq_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stream_active) begin
                    if (byte_idx == IDX_ZERO) begin
                        buf_d   = {{(TOK_W-8){1'b0}}, byte_in};
                        exp_d   = IDX_ONE;
                        state_d = ST_COLLECT;
                    end else begin
                        seq_s   = 1'b1;
                        state_d = ST_DISCARD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (stream_active) begin
                    if (byte_idx == exp_q) begin
                        buf_d[{exp_q, 3'b000} +: 8] = byte_in;
                        if (exp_q == IDX_LAST) begin
                            done_s  = 1'b1;
                            exp_d   = IDX_ZERO;
                            state_d = ST_IDLE;
                        end else begin
                            exp_d = exp_q + IDX_ONE;
                        end
                    end else begin
                        seq_s   = 1'b1;
                        exp_d   = IDX_ZERO;
                        state_d = ST_DISCARD;
                    end
                end else begin
                    short_s = 1'b1;
                    exp_d   = IDX_ZERO;
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (!stream_active) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                exp_d   = IDX_ZERO;
            end
        endcase
    end

    // Output register, overrun detection and error accumulation
    always_comb begin
        hs_s    = valid_q & token_ready;
        load_s  = done_s & (~valid_q | token_ready);
        ovr_s   = done_s & valid_q & ~token_ready;
        token_d = load_s ? buf_d : token_q;
        count_d = load_s ? (count_q + COUNT_W'(1)) : count_q;
        if (load_s) begin
            valid_d = 1'b1;
        end else if (hs_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        // Detected and still-visible pulses both set the bit, so clr_err never hides an event.
        sticky_d = (clr_err ? 3'b000 : sticky_q) | {ovr_s, seq_s, short_s} | {ovr_q, seq_q, short_q};
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            exp_q    <= IDX_ZERO;
            buf_q    <= {TOK_W{1'b0}};
            token_q  <= {TOK_W{1'b0}};
            valid_q  <= 1'b0;
            short_q  <= 1'b0;
            seq_q    <= 1'b0;
            ovr_q    <= 1'b0;
            sticky_q <= 3'b000;
            count_q  <= {COUNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            buf_q    <= buf_d;
            token_q  <= token_d;
            valid_q  <= valid_d;
            short_q  <= short_s;
            seq_q    <= seq_s;
            ovr_q    <= ovr_s;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign token_out   = token_q;
    assign token_valid = valid_q;
    assign err_short   = short_q;
    assign err_seq     = seq_q;
    assign err_overrun = ovr_q;
    assign err_sticky  = sticky_q;
    assign tok_count   = count_q;

endmodule
